// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner, debouncer and decimal entry builder.
// Scans one active-low row at a time, debounces full-matrix snapshots, decodes
// single key presses and accumulates a 0..255 ticket quantity committed on '#'.
// Optional macro KEYPAD_BACKSPACE_EN turns key D into a backspace.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   col[3:0]     : keypad columns, active-low, asynchronous
//   row[3:0]     : keypad row drive, active-low one-hot
//   value        : live entry value
//   digit_count  : digits entered so far (0..3)
//   key_code     : code of last accepted key
//   key_pulse    : one-cycle strobe per accepted key
//   entry_value  : last committed value
//   entry_valid  : one-cycle commit strobe
//   reject       : one-cycle strobe when a key is refused
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 16384,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [7:0] value,
  output logic [1:0] digit_count,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic [7:0] entry_value,
  output logic       entry_valid,
  output logic       reject
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_BLOCKED} state_t;

  logic [3:0]       col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic [15:0]      scan_snap, prev_snap, stable_map;
  logic [CNT_W-1:0] stable_cnt;
  logic             map_upd;
  state_t           state_q, state_d;

  logic             scan_tick_c;
  logic [15:0]      full_snap_c;

  assign scan_tick_c = (div_cnt == DIV_LAST);
  // Row 3 lands in the snapshot on the same edge it is compared.
  assign full_snap_c = {~col_sync, scan_snap[11:0]};

  // Column synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  // Row scan, snapshot capture and debounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      row_idx    <= 2'd0;
      row        <= 4'b1110;
      scan_snap  <= 16'h0;
      prev_snap  <= 16'h0;
      stable_map <= 16'h0;
      stable_cnt <= '0;
      map_upd    <= 1'b0;
    end else begin
      map_upd <= 1'b0;
      if (scan_tick_c) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        row     <= {row[2:0], row[3]};
        scan_snap[{row_idx, 2'b00} +: 4] <= ~col_sync;
        if (row_idx == 2'd3) begin
          if (full_snap_c == prev_snap) begin
            if (stable_cnt != CNT_MAX) begin
              stable_cnt <= stable_cnt + CNT_W'(1);
              if (stable_cnt == CNT_PRE) begin
                stable_map <= full_snap_c;
                map_upd    <= 1'b1;
              end
            end
          end else begin
            stable_cnt <= '0;
            prev_snap  <= full_snap_c;
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Matrix position -> key code.
  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    case (idx)
      4'd0:  key_lut = 4'h1;
      4'd1:  key_lut = 4'h2;
      4'd2:  key_lut = 4'h3;
      4'd3:  key_lut = 4'hA;
      4'd4:  key_lut = 4'h4;
      4'd5:  key_lut = 4'h5;
      4'd6:  key_lut = 4'h6;
      4'd7:  key_lut = 4'hB;
      4'd8:  key_lut = 4'h7;
      4'd9:  key_lut = 4'h8;
      4'd10: key_lut = 4'h9;
      4'd11: key_lut = 4'hC;
      4'd12: key_lut = 4'hE;
      4'd13: key_lut = 4'h0;
      4'd14: key_lut = 4'hF;
      default: key_lut = 4'hD;
    endcase
  endfunction

  logic [3:0]  key_idx_c, key_c;
  logic        one_hot_c;
  logic [11:0] prod_c;

  always_comb begin
    key_idx_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (stable_map[i]) key_idx_c = 4'(i);
    end
  end

  assign key_c     = key_lut(key_idx_c);
  assign one_hot_c = (stable_map != 16'h0) && ((stable_map & (stable_map - 16'd1)) == 16'h0);
  assign prod_c    = 12'(value) * 12'd10 + 12'(key_c);

  logic [7:0] value_d, entry_d;
  logic [1:0] count_d;
  logic [3:0] code_d;
  logic       pulse_d, valid_d, reject_d;

  // Press FSM and key actions, evaluated once per stable-map update.
  always_comb begin
    state_d  = state_q;
    value_d  = value;
    count_d  = digit_count;
    code_d   = key_code;
    entry_d  = entry_value;
    pulse_d  = 1'b0;
    valid_d  = 1'b0;
    reject_d = 1'b0;
    if (map_upd) begin
      case (state_q)
        S_IDLE: begin
          if (one_hot_c) begin
            state_d = S_PRESSED;
            pulse_d = 1'b1;
            code_d  = key_c;
            if (key_c <= 4'd9) begin
              if (digit_count == 2'd3 || prod_c > 12'd255) begin
                reject_d = 1'b1;
              end else begin
                value_d = prod_c[7:0];
                count_d = digit_count + 2'd1;
              end
            end else begin
              case (key_c)
                4'hE: begin
                  value_d = 8'd0;
                  count_d = 2'd0;
                end
                4'hF: begin
                  if (digit_count != 2'd0) begin
                    entry_d = value;
                    valid_d = 1'b1;
                    value_d = 8'd0;
                    count_d = 2'd0;
                  end else begin
                    reject_d = 1'b1;
                  end
                end
`ifdef KEYPAD_BACKSPACE_EN
                4'hD: begin
                  if (digit_count != 2'd0) begin
                    value_d = value / 8'd10;
                    count_d = digit_count - 2'd1;
                  end else begin
                    reject_d = 1'b1;
                  end
                end
`endif
                default: ;
              endcase
            end
          end else if (stable_map != 16'h0) begin
            state_d = S_BLOCKED;
          end
        end
        S_PRESSED, S_BLOCKED: begin
          if (stable_map == 16'h0) state_d = S_IDLE;
        end
        default: state_d = S_BLOCKED;
      endcase
    end
  end

  // Reset enters BLOCKED so a key held across reset must be released first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_BLOCKED;
      value       <= 8'd0;
      digit_count <= 2'd0;
      key_code    <= 4'd0;
      key_pulse   <= 1'b0;
      entry_value <= 8'd0;
      entry_valid <= 1'b0;
      reject      <= 1'b0;
    end else begin
      state_q     <= state_d;
      value       <= value_d;
      digit_count <= count_d;
      key_code    <= code_d;
      key_pulse   <= pulse_d;
      entry_value <= entry_d;
      entry_valid <= valid_d;
      reject      <= reject_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed bench for keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A keypad model pulls columns low while a held key's row is driven.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] value;
  logic [1:0] digit_count;
  logic [3:0] key_code;
  logic       key_pulse;
  logic [7:0] entry_value;
  logic       entry_valid;
  logic       reject;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .value(value),
    .digit_count(digit_count), .key_code(key_code), .key_pulse(key_pulse),
    .entry_value(entry_value), .entry_valid(entry_valid), .reject(reject)
  );

  always #5 clk = ~clk;

  logic [15:0] held = 16'h0;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && held[r*4+c]) col[c] = 1'b0;
  end

  int n_cmp = 0, n_fail = 0;
  int n_pulse = 0, n_rej = 0, n_valid = 0, n_b2b = 0;
  logic p_pulse = 1'b0, p_rej = 1'b0, p_valid = 1'b0;

  // Strobe counters and back-to-back detection.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_pulse) n_pulse++;
      if (reject) n_rej++;
      if (entry_valid) n_valid++;
      if ((key_pulse && p_pulse) || (reject && p_rej) || (entry_valid && p_valid)) n_b2b++;
    end
    p_pulse = key_pulse;
    p_rej   = reject;
    p_valid = entry_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bit_of(input logic [3:0] code);
    case (code)
      4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
      4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
      4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
      4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(input logic [3:0] code);
    return 16'(1) << bit_of(code);
  endfunction

  task automatic tap(input logic [3:0] code);
    held = mask_of(code);
    repeat (150) @(negedge clk);
    held = 16'h0;
    repeat (150) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] key;
    int value;
    int count;
    int code;
    int d_pulse;
    int d_rej;
    int d_valid;
    int entry;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int b_pulse, b_rej, b_valid;

    vecs[0]  = '{4'h1,   1, 1, 4'h1, 1, 0, 0,   0};
    vecs[1]  = '{4'h2,  12, 2, 4'h2, 1, 0, 0,   0};
    vecs[2]  = '{4'h8, 128, 3, 4'h8, 1, 0, 0,   0};
    vecs[3]  = '{4'hF,   0, 0, 4'hF, 1, 0, 1, 128};
    vecs[4]  = '{4'h2,   2, 1, 4'h2, 1, 0, 0, 128};
    vecs[5]  = '{4'h5,  25, 2, 4'h5, 1, 0, 0, 128};
    vecs[6]  = '{4'h6,  25, 2, 4'h6, 1, 1, 0, 128};
    vecs[7]  = '{4'h5, 255, 3, 4'h5, 1, 0, 0, 128};
    vecs[8]  = '{4'h0, 255, 3, 4'h0, 1, 1, 0, 128};
    vecs[9]  = '{4'hE,   0, 0, 4'hE, 1, 0, 0, 128};
    vecs[10] = '{4'hF,   0, 0, 4'hF, 1, 1, 0, 128};
    vecs[11] = '{4'hA,   0, 0, 4'hA, 1, 0, 0, 128};
    vecs[12] = '{4'h9,   9, 1, 4'h9, 1, 0, 0, 128};
    vecs[13] = '{4'h7,  97, 2, 4'h7, 1, 0, 0, 128};
    vecs[14] = '{4'hF,   0, 0, 4'hF, 1, 0, 1,  97};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_row", int'(row), 4'b1110);
    chk("rst_value", int'(value), 0);
    chk("rst_count", int'(digit_count), 0);
    chk("rst_strobes", int'({key_pulse, entry_valid, reject}), 0);
    rst = 1'b0;

    // Row sequence, 4 clocks per row.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] er;
      er = ~(4'b0001 << (k / 4));
      chk($sformatf("row_seq%0d", k), int'(row), int'(er));
      @(negedge clk);
    end

    // Idle: no strobes, value stays 0.
    repeat (1000) @(negedge clk);
    chk("idle_pulses", n_pulse + n_rej + n_valid, 0);
    chk("idle_value", int'(value), 0);

    // Table of single-key taps.
    for (int i = 0; i < 15; i++) begin
      b_pulse = n_pulse; b_rej = n_rej; b_valid = n_valid;
      tap(vecs[i].key);
      chk($sformatf("v%0d_value", i), int'(value), vecs[i].value);
      chk($sformatf("v%0d_count", i), int'(digit_count), vecs[i].count);
      chk($sformatf("v%0d_code", i), int'(key_code), vecs[i].code);
      chk($sformatf("v%0d_pulse", i), n_pulse - b_pulse, vecs[i].d_pulse);
      chk($sformatf("v%0d_reject", i), n_rej - b_rej, vecs[i].d_rej);
      chk($sformatf("v%0d_valid", i), n_valid - b_valid, vecs[i].d_valid);
      chk($sformatf("v%0d_entry", i), int'(entry_value), vecs[i].entry);
    end

`ifdef KEYPAD_BACKSPACE_EN
    // Backspace: 1,9,D -> 1; D -> 0; D with nothing entered -> reject.
    tap(4'hE); tap(4'h1); tap(4'h9); tap(4'hD);
    chk("bs1_value", int'(value), 1);
    chk("bs1_count", int'(digit_count), 1);
    tap(4'hD);
    chk("bs2_value", int'(value), 0);
    chk("bs2_count", int'(digit_count), 0);
    b_rej = n_rej;
    tap(4'hD);
    chk("bs3_reject", n_rej - b_rej, 1);
    chk("bs3_value", int'(value), 0);
`else
    // D with no backspace: pulse and code only.
    tap(4'h3);
    b_pulse = n_pulse; b_rej = n_rej;
    tap(4'hD);
    chk("d_code", int'(key_code), 4'hD);
    chk("d_pulse", n_pulse - b_pulse, 1);
    chk("d_reject", n_rej - b_rej, 0);
    chk("d_value", int'(value), 3);
    chk("d_count", int'(digit_count), 1);
`endif

    // Bouncing 5, then held: exactly one accepted press, no repeat.
    tap(4'hE);
    b_pulse = n_pulse;
    for (int k = 0; k < 14; k++) begin
      held = k[0] ? 16'h0 : mask_of(4'h5);
      repeat (3) @(negedge clk);
    end
    held = mask_of(4'h5);
    repeat (500) @(negedge clk);
    chk("bounce_pulses", n_pulse - b_pulse, 1);
    chk("bounce_value", int'(value), 5);
    held = 16'h0;
    repeat (150) @(negedge clk);

    // Ghost: 3 and 6 together never produce a key; 7 afterwards is fine.
    tap(4'hE);
    b_pulse = n_pulse;
    held = mask_of(4'h3) | mask_of(4'h6);
    repeat (150) @(negedge clk);
    held = 16'h0;
    repeat (150) @(negedge clk);
    chk("ghost_pulses", n_pulse - b_pulse, 0);
    chk("ghost_value", int'(value), 0);
    tap(4'h7);
    chk("after_ghost_pulses", n_pulse - b_pulse, 1);
    chk("after_ghost_value", int'(value), 7);

    // Reset while 4 is held: cleared, and 4 must be released first.
    held = mask_of(4'h4);
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_row", int'(row), 4'b1110);
    chk("midrst_value", int'(value), 0);
    chk("midrst_count", int'(digit_count), 0);
    chk("midrst_code", int'(key_code), 0);
    chk("midrst_entry", int'(entry_value), 0);
    chk("midrst_strobes", int'({key_pulse, entry_valid, reject}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b_pulse = n_pulse;
    repeat (300) @(negedge clk);
    chk("held_after_rst_pulses", n_pulse - b_pulse, 0);
    chk("held_after_rst_value", int'(value), 0);
    held = 16'h0;
    repeat (150) @(negedge clk);
    tap(4'h4);
    chk("repress_pulses", n_pulse - b_pulse, 1);
    chk("repress_value", int'(value), 4);

    chk("no_back_to_back", n_b2b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the multiplexed 7-segment display path.
- Drives a 4x4 matrix keypad one active-low row at a time, samples the active-low columns, debounces the samples and decodes single key presses.
- Builds the decimal ticket quantity (0..255) the user types in. Hands it to the booking logic with a one-cycle commit pulse on '#'.
- The live entry value also feeds the display controller so the user sees digits as they are typed.

Parameters:
- SCAN_DIV, 16384, clk cycles each row is driven; columns are sampled on the last cycle of each row period (min 2).
- DEBOUNCE_SCANS, 4, consecutive identical full-scan snapshots needed before the key matrix is treated as stable (min 1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- col  input  4  keypad columns, active-low (pulled up externally, asynchronous to clk)
- row  output  4  keypad row drive, active-low one-hot
- value  output  8  live entry value, binary 0..255
- digit_count  output  2  digits currently entered, 0..3
- key_code  output  4  code of last accepted key
- key_pulse  output  1  one-cycle strobe per accepted key
- entry_value  output  8  committed value, held until next commit
- entry_valid  output  1  one-cycle commit strobe
- reject  output  1  one-cycle strobe when a digit is refused

Behaviour:
- Reset (async, rst=1): row=4'b1110; value=0; digit_count=0; key_code=0; key_pulse=0; entry_value=0; entry_valid=0; reject=0; all counters, snapshots and FSM cleared. Reset mid-scan or mid-press discards everything; a key still held after reset must be released before it can be accepted.
- Synchronise col through a 2-flop synchroniser before use.
- Scan sequence:
  - A divider counts 0..SCAN_DIV-1; at terminal count the row index advances 0->1->2->3->0.
  - row = ~(1<<index).
  - At terminal count, before advancing, the inverted synchronised columns are stored into bits [index*4+3:index*4] of a 16-bit scan snapshot.
  - After row 3 the snapshot is complete. If it equals the previous complete snapshot, the stable counter increments (saturating at DEBOUNCE_SCANS); otherwise the counter is cleared and the previous snapshot is updated.
  - The stable map is updated when the counter reaches DEBOUNCE_SCANS.
- Key map (row,col) -> key_code:
  - r0: 1,2,3,A(0xA)
  - r1: 4,5,6,B(0xB)
  - r2: 7,8,9,C(0xC)
  - r3: *(0xE),0,#(0xF),D(0xD)
- FSM, evaluated when the stable map updates:
  - IDLE:
    - exactly one bit set -> PRESSED, key_pulse=1 for 1 cycle, key_code latched, action applied the same cycle.
    - more than one bit set -> BLOCKED, no action.
    - zero bits -> stay in IDLE.
  - PRESSED: stable map all-zero -> IDLE. Any other map (including an added second key) -> stay in PRESSED; no repeat, no second action.
  - BLOCKED: stable map all-zero -> IDLE. Multi-key ghosting never produces a key.
- Actions:
  - Digit d:
    - If digit_count==3 or value*10+d > 255: value unchanged, reject=1 for 1 cycle.
    - Otherwise value <= value*10+d and digit_count+1.
    - Compute the product in 12 bits and compare before truncating.
  - '*': value=0, digit_count=0.
  - '#':
    - If digit_count>0: entry_value<=value, entry_valid=1 for 1 cycle, and value/digit_count clear on the same edge.
    - If digit_count==0: no commit, reject=1.
  - A, B, C: key_pulse only, no effect on value. D: same, unless the optional feature below is enabled.
- Latency: key_pulse occurs one cycle after the scan-end edge on which the stable counter reaches DEBOUNCE_SCANS. key_pulse, entry_valid and reject never assert two cycles in a row.

Optional Feature:
- KEYPAD_BACKSPACE_EN:
  - Defined: key D acts as backspace. If digit_count>0, value <= value/10 and digit_count-1. If digit_count==0, reject=1.
  - Undefined: D only produces key_pulse with key_code=0xD.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2; a bench keypad model pulls col low while the pressed key's row is driven.
- Reset release with no key -> row cycles 1110,1101,1011,0111 each 4 clks; value=0, no strobes for 1000 clks.
- Press 1, release, 2, release, 8, release, then '#' -> key_pulse x4, value 1->12->128; entry_valid one cycle with entry_value=128, then value=0 and digit_count=0.
- Enter 2,5 then 6 -> value stays 25, reject pulse; then 5 -> value=255, digit_count=3; another 0 -> reject.
- Key 5 bouncing (toggling every 3 clks for 40 clks) then held -> exactly one key_pulse, value=5; holding 500 clks gives no repeat.
- Press 3 and 6 together, then release both -> no key_pulse; then press 7 -> accepted, value=7.
- With KEYPAD_BACKSPACE_EN: enter 1,9,D -> value=1, digit_count=1; D, D -> value=0, then reject. Assert rst while 4 is held -> all outputs 0; no key_pulse until 4 is released and pressed again.
